// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver: FSM encoding,
// scan-code values, key-vector bit positions and the key decode helpers.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  localparam int KV_W     = 7;
  localparam int KV_UP    = 0;
  localparam int KV_DOWN  = 1;
  localparam int KV_LEFT  = 2;
  localparam int KV_RIGHT = 3;
  localparam int KV_ENTER = 4;
  localparam int KV_F1    = 5;
  localparam int KV_F2    = 6;

  typedef struct packed {
    logic [7:0]      code;
    logic [KV_W-1:0] vec;
  } ps2_key_t;

  function automatic logic [KV_W-1:0] decode_key(input logic [7:0] code);
    logic [KV_W-1:0] v;
    v = '0;
    case (code)
      SC_UP:    v[KV_UP]    = 1'b1;
      SC_DOWN:  v[KV_DOWN]  = 1'b1;
      SC_LEFT:  v[KV_LEFT]  = 1'b1;
      SC_RIGHT: v[KV_RIGHT] = 1'b1;
      SC_ENTER: v[KV_ENTER] = 1'b1;
      SC_F1:    v[KV_F1]    = 1'b1;
      SC_F2:    v[KV_F2]    = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  // Codes that still decode when preceded by the E0 prefix.
  function automatic logic is_nav(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) || (code == SC_LEFT) ||
           (code == SC_RIGHT) || (code == SC_ENTER);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchroniser, stability filter (idle high) and a
// one-cycle strobe on each accepted 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt,
  output logic fall
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt   <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      fall   <= 1'b0;
      if (sync_q[1] == filt) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        // New level held long enough; a change away from 1 is a falling edge.
        filt  <= sync_q[1];
        fall  <= filt;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver with key decode and ack handshake.
// Optional build macro PS2_BREAK_FILTER_EN: swallow F0 break sequences.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic            key_ack,
  output logic [7:0]      scan_code,
  output logic            key_ready,
  output logic [KV_W-1:0] key_vec,
  output logic            overrun,
  output logic            frame_err
);
  localparam int STAGES = 1;
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);

  // Line 0 is the PS/2 clock, line 1 the data.
  logic [1:0] raw, filt, fall;
  assign raw = {ps2_data, ps2_clk};

  for (genvar g = 0; g < 2; g++) begin : g_line
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[g]),
      .filt (filt[g]),
      .fall (fall[g])
    );
  end

  logic clk_fall, data_f, unused_data_fall;
  assign clk_fall         = fall[0];
  assign data_f           = filt[1];
  assign unused_data_fall = fall[1];

  ps2_state_e    state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          to_hit, shift_en, par_en, stop_edge, to_abort, frame_ok;
  logic [STAGES:0] vld_pipe;

  assign to_hit = (to_cnt_q >= TO_LIM);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_edge = 1'b0;
    to_abort  = 1'b0;
    if (state_q != IDLE && !clk_fall && to_hit) begin
      state_d  = IDLE;
      to_abort = 1'b1;
    end else if (clk_fall) begin
      case (state_q)
        IDLE:   if (!data_f) state_d = DATA;
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_en  = 1'b1;
          state_d = STOP;
        end
        STOP: begin
          stop_edge = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
    end else begin
      if (shift_en) shift_q <= {data_f, shift_q[7:1]};
      if (state_q == IDLE)  bit_cnt_q <= '0;
      else if (shift_en)    bit_cnt_q <= bit_cnt_q + 1'b1;
      if (par_en) par_q <= data_f;
    end
  end

  // Idle time inside a frame; any clock edge restarts the count.
  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE || clk_fall) to_cnt_q <= '0;
    else                                      to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign frame_ok    = stop_edge && data_f && (^{shift_q, par_q});
  assign vld_pipe[0] = frame_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      frame_err          <= 1'b0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      frame_err          <= (stop_edge && !frame_ok) || to_abort;
    end
  end

  // Prefix handling on the accepted byte.
  logic     accept, deliver, set_ext, clr_ext, ext_q;
  ps2_key_t dlv;
  assign accept = vld_pipe[STAGES];

`ifdef PS2_BREAK_FILTER_EN
  logic brk_q, set_brk, clr_brk;
`endif

  always_comb begin
    deliver  = 1'b0;
    set_ext  = 1'b0;
    clr_ext  = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
    set_brk  = 1'b0;
    clr_brk  = 1'b0;
`endif
    dlv.code = shift_q;
    dlv.vec  = decode_key(shift_q);
    if (ext_q && !is_nav(shift_q)) dlv.vec = '0;
    if (accept) begin
      if (shift_q == SC_EXT) begin
        set_ext = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
      end else if (shift_q == SC_BRK) begin
        set_brk = 1'b1;
      end else if (brk_q) begin
        clr_brk = 1'b1;
        clr_ext = 1'b1;
`endif
      end else begin
        deliver = 1'b1;
        clr_ext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        ext_q <= 1'b0;
    else if (set_ext) ext_q <= 1'b1;
    else if (clr_ext) ext_q <= 1'b0;
  end

`ifdef PS2_BREAK_FILTER_EN
  always_ff @(posedge clk) begin
    if (reset)        brk_q <= 1'b0;
    else if (set_brk) brk_q <= 1'b1;
    else if (clr_brk) brk_q <= 1'b0;
  end
`endif

  // A new code beats a same-cycle ack; overrun only when nothing acked it.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_code <= '0;
      key_vec   <= '0;
      key_ready <= 1'b0;
      overrun   <= 1'b0;
    end else if (deliver) begin
      scan_code <= dlv.code;
      key_vec   <= dlv.vec;
      key_ready <= 1'b1;
      if (key_ready && !key_ack) overrun <= 1'b1;
    end else if (key_ack && key_ready) begin
      key_ready <= 1'b0;
      key_vec   <= '0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: scoreboard of expected deliveries plus
// status checks after each directed step.
module tb_ps2_scancode_rx;
  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ack = 1'b0;
  logic [7:0] scan_code;
  logic       key_ready;
  logic [6:0] key_vec;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;

  typedef struct {
    logic [7:0] code;
    logic [6:0] vec;
  } exp_t;
  exp_t exp_q[$];

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_ack  (key_ack),
    .scan_code(scan_code),
    .key_ready(key_ready),
    .key_vec  (key_vec),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Delivery monitor: a new code shows up as key_ready rising or scan_code changing.
  logic       rdy_prev = 1'b0;
  logic [7:0] code_prev = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && key_ready && (!rdy_prev || scan_code != code_prev)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", {24'h0, scan_code}, 32'h100);
      end else begin
        e = exp_q.pop_front();
        check("delivery", {17'h0, scan_code, key_vec}, {17'h0, e.code, e.vec});
      end
    end
    if (frame_err) err_pulses++;
    rdy_prev  = key_ready;
    code_prev = scan_code;
  end

  task automatic push(input logic [7:0] c, input logic [6:0] v);
    exp_t e;
    e.code = c;
    e.vec  = v;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic ack();
    @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int e0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_scan_code", {24'h0, scan_code}, 32'h00);
    check("rst_key_ready", {31'h0, key_ready}, 32'h0);
    check("rst_key_vec",   {25'h0, key_vec}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);

    // 1: up arrow, then ack.
    push(8'h75, 7'b0000001);
    good(8'h75);
    check("t1_ready", {31'h0, key_ready}, 32'h1);
    check("t1_vec", {25'h0, key_vec}, 32'h01);
    ack();
    check("t1_ack_ready", {31'h0, key_ready}, 32'h0);
    check("t1_ack_vec", {25'h0, key_vec}, 32'h0);
    check("t1_ack_code_kept", {24'h0, scan_code}, 32'h75);

    // Ack with nothing pending does nothing.
    ack();
    check("idle_ack_ready", {31'h0, key_ready}, 32'h0);

    // 2: bad parity is dropped with a frame_err pulse.
    e0 = err_pulses;
    send_frame(8'h5A, 1'b1, 1'b0, 11);
    check("t2_err_pulse", err_pulses - e0, 1);
    check("t2_ready", {31'h0, key_ready}, 32'h0);
    check("t2_code", {24'h0, scan_code}, 32'h75);

    // Bad stop bit likewise.
    e0 = err_pulses;
    send_frame(8'h72, 1'b0, 1'b1, 11);
    check("stop_err_pulse", err_pulses - e0, 1);
    check("stop_ready", {31'h0, key_ready}, 32'h0);

    // 3: overrun on unacked replacement.
    push(8'h72, 7'b0000010);
    good(8'h72);
    check("t3_no_overrun_yet", {31'h0, overrun}, 32'h0);
    push(8'h6B, 7'b0000100);
    good(8'h6B);
    check("t3_code", {24'h0, scan_code}, 32'h6B);
    check("t3_vec", {25'h0, key_vec}, 32'h04);
    check("t3_overrun", {31'h0, overrun}, 32'h1);
    ack();
    check("t3_ack_overrun", {31'h0, overrun}, 32'h0);
    check("t3_ack_ready", {31'h0, key_ready}, 32'h0);

    // 4: E0 74 delivers only 74, decoded.
    good(8'hE0);
    check("t4_e0_not_ready", {31'h0, key_ready}, 32'h0);
    push(8'h74, 7'b0001000);
    good(8'h74);
    check("t4_vec", {25'h0, key_vec}, 32'h08);
    ack();

    // Extended non-navigation code decodes to zero.
    good(8'hE0);
    push(8'h05, 7'b0000000);
    good(8'h05);
    check("ext_f1_vec", {25'h0, key_vec}, 32'h0);
    check("ext_f1_ready", {31'h0, key_ready}, 32'h1);
    ack();

    // 5: 75 F0 75.
    push(8'h75, 7'b0000001);
    good(8'h75);
    ack();
`ifdef PS2_BREAK_FILTER_EN
    good(8'hF0);
    check("t5_f0_not_ready", {31'h0, key_ready}, 32'h0);
    good(8'h75);
    check("t5_break_dropped", {31'h0, key_ready}, 32'h0);
`else
    push(8'hF0, 7'b0000000);
    good(8'hF0);
    check("t5_f0_ready", {31'h0, key_ready}, 32'h1);
    ack();
    push(8'h75, 7'b0000001);
    good(8'h75);
    check("t5_75_ready", {31'h0, key_ready}, 32'h1);
`endif
    ack();

    // 6: mid-frame stall times out, then a clean F1 frame.
    e0 = err_pulses;
    send_frame(8'h12, 1'b0, 1'b0, 5);
    repeat (TIMEOUT_CYC / 2) @(negedge clk);
    check("t6_no_early_err", err_pulses - e0, 0);
    repeat (TIMEOUT_CYC) @(negedge clk);
    check("t6_timeout_err", err_pulses - e0, 1);
    push(8'h05, 7'b0100000);
    good(8'h05);
    check("t6_code", {24'h0, scan_code}, 32'h05);
    check("t6_vec", {25'h0, key_vec}, 32'h20);
    ack();

    // Stall again but reset mid-frame: no error afterwards.
    e0 = err_pulses;
    send_frame(8'h12, 1'b0, 1'b0, 5);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (TIMEOUT_CYC + 200) @(negedge clk);
    check("t6_reset_no_err", err_pulses - e0, 0);
    check("t6_reset_code", {24'h0, scan_code}, 32'h00);
    push(8'h6B, 7'b0000100);
    good(8'h6B);
    check("t6_after_reset_ready", {31'h0, key_ready}, 32'h1);
    ack();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
